// File: rtl/bayer_mosaic_pkg.sv
// Shared image geometry, Bayer phase encoding and mosaic FSM states.
package bayer_mosaic_pkg;

    localparam int unsigned WIDTH      = 128;
    localparam int unsigned HEIGHT     = 128;
    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned FIFO_DEPTH = 2;

    // Phase of a pixel position, encoded as {row[0], col[0]}.
    typedef enum logic [1:0] {
        PH_G0 = 2'b00,
        PH_R  = 2'b01,
        PH_B  = 2'b10,
        PH_G1 = 2'b11
    } bayer_phase_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } mosaic_state_t;

    function automatic bayer_phase_t bayer_phase(input logic row_lsb, input logic col_lsb);
        return bayer_phase_t'({row_lsb, col_lsb});
    endfunction

endpackage

// File: rtl/bayer_mosaic_if.sv
// Channel-memory read bus and Bayer output stream of the mosaic block.
interface bayer_mosaic_if #(
    parameter int unsigned ADDR_W = bayer_mosaic_pkg::ADDR_W
) ();

    logic              rd_r;
    logic              rd_g;
    logic              rd_b;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_g;
    logic [ADDR_W-1:0] addr_b;
    logic [7:0]        rdata_r;
    logic [7:0]        rdata_g;
    logic [7:0]        rdata_b;

    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;

    // The mosaic block: reads the memories and drives the pixel stream.
    modport master (
        output rd_r, rd_g, rd_b, addr_r, addr_g, addr_b,
        input  rdata_r, rdata_g, rdata_b,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    // Memories and pixel consumer.
    modport slave (
        input  rd_r, rd_g, rd_b, addr_r, addr_g, addr_b,
        output rdata_r, rdata_g, rdata_b,
        input  out_valid, out_data, out_last,
        output out_ready
    );

endinterface

// File: rtl/bayer_mosaic_fifo.sv
// Small synchronous FIFO holding returned pixels and their end-of-frame flag.
module mosaic_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         push_last,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_valid,
    output logic [DATA_W-1:0]            head_data,
    output logic                         head_last
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  last_mem;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= push_data;
            last_mem[wr_ptr] <= push_last;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    // Head outputs read as zero when empty so the stream is quiet after reset.
    assign head_data  = head_valid ? data_mem[rd_ptr] : '0;
    assign head_last  = head_valid ? last_mem[rd_ptr] : 1'b0;

    ap_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_q == CNT_W'(DEPTH))));

    ap_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && (count_q == '0)));

endmodule

// File: rtl/bayer_mosaic.sv
// Reads the R/G/B channel memories in raster order and emits one Bayer pixel per position.
module bayer_mosaic #(
    parameter int unsigned WIDTH      = bayer_mosaic_pkg::WIDTH,
    parameter int unsigned HEIGHT     = bayer_mosaic_pkg::HEIGHT,
    parameter int unsigned ADDR_W     = bayer_mosaic_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH = bayer_mosaic_pkg::FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    bayer_mosaic_if.master bus,
    output logic           busy,
    output logic           done
);

    import bayer_mosaic_pkg::*;

    localparam int unsigned COL_W = $clog2(WIDTH);
    localparam int unsigned ROW_W = ADDR_W - COL_W;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    mosaic_state_t    state_q;
    mosaic_state_t    state_d;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;

    logic             frame_clear;
    logic             issue;
    logic             last_pos;
    bayer_phase_t     rd_phase;

    logic             pend_q;
    bayer_phase_t     pend_phase_q;
    logic             pend_last_q;

    logic             push;
    logic [7:0]       push_data;
    logic             pop;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   committed;
    logic             credit_ok;

    assign last_pos = (row_q == ROW_W'(HEIGHT - 1)) && (col_q == COL_W'(WIDTH - 1));
    assign rd_phase = bayer_phase(row_q[0], col_q[0]);
    assign pop      = bus.out_valid && bus.out_ready;

    // Slots already spoken for after this cycle's pop: buffered plus the read in flight.
    assign committed = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(pend_q) - (CNT_W+1)'(pop);
    assign credit_ok = committed < (CNT_W+1)'(FIFO_DEPTH);

    // Frame sequencing state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, read issue and status outputs.
    always_comb begin
        state_d     = state_q;
        frame_clear = 1'b0;
        issue       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_clear = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_pos) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Empty is judged after this cycle's pop, so done follows the last handshake directly.
                if (committed == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Raster position of the next read; wraps to (0,0) after the final pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else if (frame_clear) begin
            row_q <= '0;
            col_q <= '0;
        end else if (issue) begin
            if (col_q == COL_W'(WIDTH - 1)) begin
                col_q <= '0;
                row_q <= last_pos ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Enable only the memory holding the channel this position samples.
    always_comb begin
        bus.rd_r = 1'b0;
        bus.rd_g = 1'b0;
        bus.rd_b = 1'b0;
        if (issue) begin
            case (rd_phase)
                PH_R:    bus.rd_r = 1'b1;
                PH_B:    bus.rd_b = 1'b1;
                default: bus.rd_g = 1'b1;
            endcase
        end
    end

    assign bus.addr_r = {row_q, col_q};
    assign bus.addr_g = {row_q, col_q};
    assign bus.addr_b = {row_q, col_q};

    // Track the one-cycle read in flight with its phase and end-of-frame flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q       <= 1'b0;
            pend_phase_q <= PH_G0;
            pend_last_q  <= 1'b0;
        end else if (frame_clear) begin
            pend_q       <= 1'b0;
            pend_phase_q <= PH_G0;
            pend_last_q  <= 1'b0;
        end else begin
            pend_q <= issue;
            if (issue) begin
                pend_phase_q <= rd_phase;
                pend_last_q  <= last_pos;
            end
        end
    end

    assign push = pend_q;

    // Pick the returned byte from the memory that was actually read.
    always_comb begin
        push_data = '0;
        case (pend_phase_q)
            PH_R:    push_data = bus.rdata_r;
            PH_B:    push_data = bus.rdata_b;
            default: push_data = bus.rdata_g;
        endcase
    end

    mosaic_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (frame_clear),
        .push       (push),
        .push_data  (push_data),
        .push_last  (pend_last_q),
        .pop        (pop),
        .count      (fifo_count),
        .head_valid (bus.out_valid),
        .head_data  (bus.out_data),
        .head_last  (bus.out_last)
    );

endmodule

// File: tb/tb_bayer_mosaic.sv
// Scoreboard bench for bayer_mosaic: ramp image memories, raster-order expected pixel queue.
module tb_bayer_mosaic;

    import bayer_mosaic_pkg::*;

    localparam int unsigned NPIX  = WIDTH * HEIGHT;
    localparam int unsigned COL_B = $clog2(WIDTH);

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;
    bit   rand_ready = 1'b0;

    bayer_mosaic_if #(.ADDR_W(ADDR_W)) bus ();

    bayer_mosaic #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ramp image: R = col, G = row, B = row ^ col.
    function automatic logic [7:0] mem_byte(input int ch, input logic [ADDR_W-1:0] a);
        logic [7:0] r;
        logic [7:0] c;
        r = 8'(a >> COL_B);
        c = 8'(a & ADDR_W'(WIDTH - 1));
        case (ch)
            0:       return c;
            1:       return r;
            default: return r ^ c;
        endcase
    endfunction

    function automatic logic [7:0] exp_pixel(input int row, input int col);
        logic [7:0] r;
        logic [7:0] c;
        r = 8'(row);
        c = 8'(col);
        case ((row % 2) * 2 + (col % 2))
            1:       return c;
            2:       return r ^ c;
            default: return r;
        endcase
    endfunction

    // Memory model: one-cycle read latency; unread channels return junk.
    initial forever begin
        @(posedge clk);
        bus.rdata_r <= bus.rd_r ? mem_byte(0, bus.addr_r) : 8'($urandom);
        bus.rdata_g <= bus.rd_g ? mem_byte(1, bus.addr_g) : 8'($urandom);
        bus.rdata_b <= bus.rd_b ? mem_byte(2, bus.addr_b) : 8'($urandom);
    end

    // Random consumer back-pressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end

    longint cyc = 0;
    longint c0  = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int         frame_req  = 0;
    int         frame_seen = 0;
    beat_t      sb[$];
    logic [7:0] cur_log [NPIX];
    logic [7:0] ref_log [NPIX];
    int         beats     = 0;
    int         first_cyc = -1;
    int         done_cnt  = 0;
    int         done_cyc  = -1;
    int         rd_cnt    = 0;
    int         last_cnt  = 0;
    int         last_idx  = -1;
    int         occ       = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    // Monitor: per-cycle protocol checks and scoreboard compare on each handshake.
    initial forever begin
        int    idx;
        int    iss;
        int    pp;
        beat_t e;
        @(negedge clk);
        if (frame_req != frame_seen) begin
            frame_seen = frame_req;
            sb.delete();
            for (int r = 0; r < int'(HEIGHT); r++) begin
                for (int c = 0; c < int'(WIDTH); c++) begin
                    e.data = exp_pixel(r, c);
                    e.last = (r == int'(HEIGHT) - 1) && (c == int'(WIDTH) - 1);
                    sb.push_back(e);
                end
            end
            beats = 0; first_cyc = -1; done_cnt = 0; done_cyc = -1;
            rd_cnt = 0; last_cnt = 0; last_idx = -1; occ = 0; prev_stall = 1'b0;
        end
        if (reset) begin
            occ = 0;
            prev_stall = 1'b0;
        end else begin
            idx = int'(cyc - c0) + 1;
            iss = int'(bus.rd_r | bus.rd_g | bus.rd_b);
            pp  = int'(bus.out_valid && bus.out_ready);
            check("rd_onehot0", $onehot0({bus.rd_r, bus.rd_g, bus.rd_b}), 1);
            check("addr_equal", (bus.addr_r == bus.addr_g) && (bus.addr_g == bus.addr_b), 1);
            check("occupancy_le_depth", (occ + iss - pp) <= int'(FIFO_DEPTH), 1);
            occ    = occ + iss - pp;
            rd_cnt = rd_cnt + iss;
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev_data);
                check("hold_last", bus.out_last, prev_last);
            end
            if (bus.out_valid && first_cyc < 0) first_cyc = idx;
            if (pp != 0) begin
                if (sb.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("pixel_data", bus.out_data, e.data);
                    check("pixel_last", bus.out_last, e.last);
                end
                if (beats < int'(NPIX)) cur_log[beats] = bus.out_data;
                if (bus.out_last) begin
                    last_cnt++;
                    last_idx = beats;
                end
                beats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = idx;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_r"}, bus.rd_r, 0);
        check({tag, "_rd_g"}, bus.rd_g, 0);
        check({tag, "_rd_b"}, bus.rd_b, 0);
        check({tag, "_addr_r"}, bus.addr_r, 0);
        check({tag, "_addr_g"}, bus.addr_g, 0);
        check({tag, "_addr_b"}, bus.addr_b, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_last"}, bus.out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic start_frame();
        frame_req++;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tag, done_cnt != 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int n = 0;
        while (beats < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, beats >= target, 1);
    endtask

    initial begin
        int nmis;
        int n;
        reset = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full ramp frame, consumer always ready.
        bus.out_ready = 1'b1;
        start_frame();
        wait_done("t1_done_seen", int'(NPIX) + 100);
        check("t1_beats", beats, NPIX);
        check("t1_first_latency", first_cyc, 3);
        check("t1_done_cycle", done_cyc, NPIX + 3);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_last_count", last_cnt, 1);
        check("t1_last_index", last_idx, NPIX - 1);
        check("t1_sb_empty", sb.size(), 0);
        check("t1_px_0_0", cur_log[0], 0);
        check("t1_px_0_1", cur_log[1], 1);
        check("t1_px_1_0", cur_log[WIDTH], 1);
        check("t1_px_1_1", cur_log[WIDTH + 1], 1);
        check("t1_idle_busy", busy, 0);
        for (int i = 0; i < int'(NPIX); i++) ref_log[i] = cur_log[i];

        // Same frame under random back-pressure.
        rand_ready = 1'b1;
        start_frame();
        wait_done("t2_done_seen", 4 * int'(NPIX));
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        check("t2_beats", beats, NPIX);
        check("t2_done_pulses", done_cnt, 1);
        check("t2_last_count", last_cnt, 1);
        nmis = 0;
        for (int i = 0; i < int'(NPIX); i++) begin
            if (cur_log[i] !== ref_log[i]) nmis++;
        end
        check("t2_seq_vs_t1", nmis, 0);

        // Consumer stalled from the start: only two reads fit, then reads stop.
        bus.out_ready = 1'b0;
        start_frame();
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t3_valid_seen", bus.out_valid, 1);
        check("t3_reads_before_stall", rd_cnt, 2);
        repeat (20) @(posedge clk);
        #1;
        check("t3_reads_during_stall", rd_cnt, 2);
        check("t3_still_valid", bus.out_valid, 1);
        check("t3_head_pixel", bus.out_data, 0);
        bus.out_ready = 1'b1;
        // A second start mid-frame must be ignored.
        wait_beats("t3_reach_500", 500, 1000);
        pulse_start();
        wait_done("t3_done_seen", int'(NPIX) + 100);
        check("t3_beats", beats, NPIX);
        check("t3_done_pulses", done_cnt, 1);
        check("t3_last_count", last_cnt, 1);
        check("t3_sb_empty", sb.size(), 0);

        // Reset in the middle of a frame, then restart.
        start_frame();
        wait_beats("t4_reach_8000", 8000, 9000);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t4_no_done", done_cnt, 0);
        check("t4_idle_busy", busy, 0);
        start_frame();
        wait_beats("t4_restart_beats", 4, 20);
        check("t4_restart_latency", first_cyc, 3);
        check("t4_first_pixel", cur_log[0], 0);
        check("t4_second_pixel", cur_log[1], 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

endmodule
